// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: round-robin shared JK flag bank, one command applied per grant
// Optional owner locking is compiled in with JKB_LOCK_EN.
module jk_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [2*NREQ-1:0]     cmd,
    input  logic [WIDTH*NREQ-1:0] mask,
    input  logic [NREQ-1:0]       lock,
    output logic [NREQ-1:0]       ack,
    output logic                  busy,
    output logic [IDW-1:0]        gnt_id,
    output logic [WIDTH-1:0]      q
);
    typedef enum logic {IDLE, EXEC} state_t;
    state_t state;
    logic [IDW-1:0] ptr;
    logic [1:0] cmd_r;
    logic [WIDTH-1:0] mask_r, jk;
    logic [NREQ-1:0] ack_r;
    logic busy_r, found, hold_ptr, hold_r;
    int win, idx;
`ifdef JKB_LOCK_EN
    logic owner_valid;
    logic [IDW-1:0] owner;
`else
    logic unused_lock;
    assign unused_lock = ^lock;
`endif
    // Winner search: first set req at or after ptr, a held owner overrides it
    always_comb begin
        win = 0;
        idx = 0;
        found = 1'b0;
        hold_ptr = 1'b0;
        for (int o = NREQ - 1; o >= 0; o--) begin
            idx = (int'(ptr) + o) % NREQ;
            if (req[idx]) begin
                win = idx;
                found = 1'b1;
            end
        end
`ifdef JKB_LOCK_EN
        if (owner_valid && req[owner]) begin
            win = int'(owner);
            found = 1'b1;
            hold_ptr = 1'b1;
        end
`endif
    end
    // Per-bit result of the latched command, before masking
    always_comb jk = cmd_r == 2'b01 ? '0 : cmd_r == 2'b10 ? '1 : cmd_r == 2'b11 ? ~q : q;
    // Two-state grant/apply FSM; q is only written here
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= '0;
            gnt_id <= '0;
            cmd_r  <= '0;
            mask_r <= '0;
            ack_r  <= '0;
            busy_r <= 1'b0;
            hold_r <= 1'b0;
            q      <= '0;
`ifdef JKB_LOCK_EN
            owner_valid <= 1'b0;
            owner       <= '0;
`endif
        end else if (state == IDLE) begin
            if (found) begin
                state  <= EXEC;
                gnt_id <= IDW'(win);
                cmd_r  <= cmd[2*win +: 2];
                mask_r <= mask[WIDTH*win +: WIDTH];
                ack_r  <= NREQ'(1) << win;
                busy_r <= 1'b1;
                hold_r <= hold_ptr;
            end
`ifdef JKB_LOCK_EN
            if (owner_valid && !req[owner]) owner_valid <= 1'b0;
`endif
        end else begin
            state  <= IDLE;
            ack_r  <= '0;
            busy_r <= 1'b0;
            q      <= (q & ~mask_r) | (jk & mask_r);
            if (!hold_r) ptr <= IDW'((int'(gnt_id) + 1) % NREQ);
`ifdef JKB_LOCK_EN
            if (lock[gnt_id]) begin
                owner_valid <= 1'b1;
                owner       <= gnt_id;
            end else if (owner_valid && owner == gnt_id) begin
                owner_valid <= 1'b0;
            end
`endif
        end
    end
    // A reset landing on the EXEC cycle suppresses that cycle's ack
    assign ack  = rst ? '0 : ack_r;
    assign busy = busy_r & ~rst;
endmodule

// File: doc/jk_bank_arbiter.md
Name: jk_bank_arbiter

Overview:
- Owns a WIDTH-bit bank of JK storage elements and shares it between NREQ requesters.
- Each requester issues a JK command (hold/clear/set/toggle) with a bit mask.
- Round-robin arbitration serialises requesters. A two-state FSM applies one command per grant.
- Sits between control agents and the shared flag/status bank that downstream logic reads via q.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, number of JK bits in the bank
- IDW, 2, width of gnt_id; must be >= clog2(NREQ)

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester request, level
- cmd  in  2*NREQ  per-requester {j,k} command, requester i at [2i+1:2i]; 00 hold, 01 clear, 10 set, 11 toggle
- mask  in  WIDTH*NREQ  per-requester bit select, requester i at [WIDTH*i +: WIDTH]
- lock  in  NREQ  per-requester ownership hold (used only with JKB_LOCK_EN)
- ack  out  NREQ  one-cycle pulse to the requester whose command is being applied
- busy  out  1  high while in EXEC
- gnt_id  out  IDW  index of the last/current winner
- q  out  WIDTH  bank contents

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On reset: q=0, ack=0, busy=0, gnt_id=0, ptr=0, state=IDLE, owner_valid=0. Reset dominates all other events.
- State IDLE:
  - If no req bit is set, stay in IDLE.
  - Otherwise pick a winner by round-robin: the first set req starting at index ptr, ascending, wrapping at NREQ-1 -> 0.
  - Latch cmd_r=cmd[winner] and mask_r=mask[winner]; gnt_id<=winner; go to EXEC.
- State EXEC, exactly one cycle:
  - busy=1 and ack[gnt_id]=1; all other ack bits are 0.
  - Bank drive: bits where mask_r=1 get {j,k}=cmd_r; bits where mask_r=0 get {j,k}=00.
  - Each bit updates at the edge ending EXEC: 00 q<=q, 01 q<=0, 10 q<=1, 11 q<=~q.
  - ptr<=(gnt_id+1) mod NREQ. Return to IDLE.
- Latency: req seen at edge N -> ack high during cycle N..N+1 -> q updated at edge N+1.
- Throughput: at most one command per 2 cycles.
- Handshake: a requester should drop req in the cycle after its ack. If req is still high when the FSM returns to IDLE, it is a new request and competes normally.
- The latched command is used. cmd and mask changes during EXEC have no effect.
- q changes only at the edge ending EXEC or on reset.
- A mask of 0x00 or cmd 00 still produces a grant and an ack; q is unchanged.
- Simultaneous requests: exactly one grant per IDLE cycle. Losers wait and no request is dropped.
- A requester waits at most NREQ-1 grants (without lock).
- Reset during EXEC: no ack is asserted in the reset cycle, the pending command is discarded, q=0.
- Only one clocked process updates q. No combinational path from req to q.

Optional Feature:
- Macro: JKB_LOCK_EN.
- With the macro:
  - When the winner has lock[gnt_id]=1 during EXEC, owner_valid<=1 and the owner is recorded.
  - In IDLE, if owner_valid is set and req[owner]=1, the owner wins regardless of ptr, and ptr is not advanced.
  - owner_valid clears when the owner is granted with lock=0, or when the owner is idle in IDLE with req=0.
  - Reset clears owner_valid.
- Without the macro: the lock port is ignored, no owner state exists, and arbitration is pure round-robin.

Test Plan:
- Reset: rst=1 for 2 cycles with random req -> q=0x00, ack=0, busy=0, gnt_id=0; no ack while rst=1.
- Single set: req[0]=1, cmd0=10, mask0=0x0F -> ack[0] pulses 1 cycle after req sampled; q=0x0F at next edge; busy high 1 cycle.
- Toggle/clear: from q=0x0F, req1 cmd=11 mask=0xFF -> q=0xF0; then req3 cmd=01 mask=0x30 -> q=0xC0; then req2 cmd=00 mask=0xFF -> ack[2], q stays 0xC0.
- Round-robin: req0, req2, req3 held continuously from ptr=0 -> grant order 0,2,3,0,2, each 2 cycles apart; ack never to two requesters at once.
- Reset mid-op: req0 cmd=10 mask=0xFF, assert rst in the EXEC cycle -> no ack[0], q=0x00, state IDLE, ptr=0.
- JKB_LOCK_EN: req0 with lock0=1 and req1 both held -> req0 granted repeatedly. Drop lock0 -> next grant to req1. Without the macro the same stimulus alternates 0,1,0,1.
